// File: rtl/sparse_compressor_4to2_if.sv
// Dense-in / packed-out stream bundle for the 2:4 sparse compressor.
// The compressor is the slave on both halves; the producer/consumer side is the master.
interface sparse_compressor_4to2_if #(
    parameter int W = 16
);
    logic           in_valid;
    logic           in_ready;
    logic [4*W-1:0] dense_vals;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] packed_vals;
    logic [3:0]     mask;

    modport master (
        output in_valid,
        output dense_vals,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  packed_vals,
        input  mask
    );

    modport slave (
        input  in_valid,
        input  dense_vals,
        input  out_ready,
        output in_ready,
        output out_valid,
        output packed_vals,
        output mask
    );
endinterface

// File: rtl/sparse_compressor_4to2.sv
// 2:4 structured-sparsity compressor: keeps the two largest-magnitude elements of a
// dense 4-element block, two-stage pipeline with valid/ready and a lossy-block counter.
module sparse_compressor_4to2 #(
    parameter int W  = 16,
    parameter int CW = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    sparse_compressor_4to2_if.slave bus,
    output logic [CW-1:0]        lossy_cnt,
    input  logic                 cnt_clear
);

    logic         stall;
    logic         accept;

    logic         s1_valid;
    logic [W-1:0] s1_raw [4];
    logic [W-1:0] s1_mag [4];
    logic [2:0]   s1_nz;

    logic         s2_lossy;

    logic [W-1:0] in_elem [4];
    logic [W-1:0] in_mag  [4];
    logic [2:0]   in_nz;

    logic [3:0]   sel_keep;
    logic [W-1:0] sel_hi;
    logic [W-1:0] sel_lo;
    logic         sel_lossy;

    assign stall       = bus.out_valid && !bus.out_ready;
    // S1 may refill while S2 is stalled as long as S1 itself is empty.
    assign bus.in_ready = !stall || !s1_valid;
    assign accept      = bus.in_valid && bus.in_ready;

    // Magnitude as W-bit unsigned; -2^(W-1) wraps to 2^(W-1), which fits.
    always_comb begin
        in_nz = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            in_elem[i] = bus.dense_vals[i*W +: W];
            in_mag[i]  = in_elem[i][W-1] ? (~in_elem[i] + W'(1)) : in_elem[i];
            in_nz      = in_nz + 3'(in_elem[i] != '0);
        end
    end

    // Each element counts how many others it outranks; equal magnitudes go to the
    // lower index, so the order is strict and exactly two elements score >= 2.
    always_comb begin
        logic [1:0] wins;
        sel_keep = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            wins = '0;
            for (int unsigned j = 0; j < 4; j++) begin
                if (i != j) begin
                    if ((s1_mag[i] > s1_mag[j]) || ((s1_mag[i] == s1_mag[j]) && (i < j))) begin
                        wins = wins + 2'd1;
                    end
                end
            end
            sel_keep[i] = (wins >= 2'd2);
        end
    end

    // Lower kept position goes to the upper half of the packed word.
    always_comb begin
        logic found;
        found  = 1'b0;
        sel_hi = '0;
        sel_lo = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (sel_keep[i]) begin
                if (!found) begin
                    sel_hi = s1_raw[i];
                    found  = 1'b1;
                end else begin
                    sel_lo = s1_raw[i];
                end
            end
        end
    end

    assign sel_lossy = (s1_nz > 3'd2);

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int unsigned i = 0; i < 4; i++) begin
                s1_raw[i] <= in_elem[i];
                s1_mag[i] <= in_mag[i];
            end
            s1_nz <= in_nz;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid        <= 1'b0;
            bus.out_valid   <= 1'b0;
            bus.packed_vals <= '0;
            bus.mask        <= '0;
            s2_lossy        <= 1'b0;
        end else begin
            if (bus.in_ready) begin
                s1_valid <= bus.in_valid;
            end
            if (!stall) begin
                bus.out_valid <= s1_valid;
                if (s1_valid) begin
                    bus.packed_vals <= {sel_hi, sel_lo};
                    bus.mask        <= sel_keep;
                    s2_lossy        <= sel_lossy;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || cnt_clear) begin
            lossy_cnt <= '0;
        end else if (bus.out_valid && bus.out_ready && s2_lossy && (lossy_cnt != '1)) begin
            lossy_cnt <= lossy_cnt + CW'(1);
        end
    end

endmodule

// File: tb/tb_sparse_compressor_4to2.sv
// Directed bench for sparse_compressor_4to2: a CW=16 instance and a CW=2 instance
// share one stimulus stream; expected values are hand-computed.
module tb_sparse_compressor_4to2;

    logic        clk;
    logic        rst;
    logic        cnt_clear;
    logic [15:0] lossy_cnt;
    logic [1:0]  lossy_cnt2;

    int n_checks = 0;
    int n_errors = 0;
    int exp_cnt  = 0;
    int exp_cnt2 = 0;

    sparse_compressor_4to2_if #(.W(16)) bus  ();
    sparse_compressor_4to2_if #(.W(16)) bus2 ();

    assign bus2.in_valid   = bus.in_valid;
    assign bus2.dense_vals = bus.dense_vals;
    assign bus2.out_ready  = bus.out_ready;

    sparse_compressor_4to2 #(.W(16), .CW(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .lossy_cnt (lossy_cnt),
        .cnt_clear (cnt_clear)
    );

    sparse_compressor_4to2 #(.W(16), .CW(2)) dut_sat (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus2.slave),
        .lossy_cnt (lossy_cnt2),
        .cnt_clear (cnt_clear)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] pack4(input logic [15:0] e0, input logic [15:0] e1,
                                          input logic [15:0] e2, input logic [15:0] e3);
        return {e3, e2, e1, e0};
    endfunction

    // Decompressor round trip: first set mask bit takes the upper packed half.
    function automatic logic [63:0] decompress(input logic [3:0] m, input logic [31:0] pk);
        logic [63:0] v;
        logic        first;
        v     = '0;
        first = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (m[i]) begin
                v[i*16 +: 16] = first ? pk[31:16] : pk[15:0];
                first = 1'b0;
            end
        end
        return v;
    endfunction

    task automatic check_counts(input string tag);
        check_val({tag, "_cnt"},  64'(lossy_cnt),  64'(exp_cnt));
        check_val({tag, "_cnt2"}, 64'(lossy_cnt2), 64'(exp_cnt2));
    endtask

    task automatic run_block(input string tag, input logic [63:0] d, input logic [3:0] em,
                             input logic [31:0] ep, input bit lossy, input bit clr);
        @(negedge clk);
        check_val({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
        bus.in_valid   = 1'b1;
        bus.dense_vals = d;
        @(posedge clk);
        #1;
        bus.in_valid   = 1'b0;
        bus.dense_vals = '0;
        @(negedge clk);
        check_val({tag, "_lat1"}, 64'(bus.out_valid), 64'd0);
        @(negedge clk);
        check_val({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
        check_val({tag, "_mask"}, 64'(bus.mask), 64'(em));
        check_val({tag, "_packed"}, 64'(bus.packed_vals), 64'(ep));
        if (clr) cnt_clear = 1'b1;
        @(negedge clk);
        cnt_clear = 1'b0;
        if (clr) begin
            exp_cnt  = 0;
            exp_cnt2 = 0;
        end else if (lossy) begin
            exp_cnt++;
            if (exp_cnt2 < 3) exp_cnt2++;
        end
        check_val({tag, "_drained"}, 64'(bus.out_valid), 64'd0);
        check_counts(tag);
    endtask

    task automatic run_stream();
        logic [63:0] blk     [5];
        logic [63:0] exp_spr [5];
        logic [3:0]  exp_msk [5];
        int          sent;
        int          got;
        logic        held;
        logic [3:0]  h_mask;
        logic [31:0] h_pk;
        blk[0] = pack4(16'd10, 16'hFFEC, 16'd30, 16'hFFD8);  exp_spr[0] = pack4(16'd0, 16'd0, 16'd30, 16'hFFD8);  exp_msk[0] = 4'b1100;
        blk[1] = pack4(16'hFF9C, 16'd0, 16'd0, 16'h0032);    exp_spr[1] = blk[1];                                  exp_msk[1] = 4'b1001;
        blk[2] = pack4(16'd1, 16'd1, 16'd1, 16'd1);          exp_spr[2] = pack4(16'd1, 16'd1, 16'd0, 16'd0);       exp_msk[2] = 4'b0011;
        blk[3] = pack4(16'd0, 16'd0, 16'd0, 16'h8000);       exp_spr[3] = blk[3];                                  exp_msk[3] = 4'b1001;
        blk[4] = pack4(16'd7, 16'hFFF9, 16'd6, 16'd0);       exp_spr[4] = pack4(16'd7, 16'hFFF9, 16'd0, 16'd0);    exp_msk[4] = 4'b0011;
        sent = 0;
        got  = 0;
        held = 1'b0;
        h_mask = '0;
        h_pk   = '0;
        for (int c = 0; c < 40 && got < 5; c++) begin
            @(negedge clk);
            bus.out_ready = !(c >= 3 && c <= 6);
            #1;
            if (held) begin
                check_val("bp_hold_mask", 64'(bus.mask), 64'(h_mask));
                check_val("bp_hold_packed", 64'(bus.packed_vals), 64'(h_pk));
            end
            if (c >= 3 && c <= 6) check_val("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
            if (bus.out_valid && bus.out_ready) begin
                check_val("bp_mask", 64'(bus.mask), 64'(exp_msk[got]));
                check_val("bp_roundtrip", decompress(bus.mask, bus.packed_vals), exp_spr[got]);
                got++;
            end
            held   = bus.out_valid && !bus.out_ready;
            h_mask = bus.mask;
            h_pk   = bus.packed_vals;
            if (sent < 5) begin
                bus.in_valid   = 1'b1;
                bus.dense_vals = blk[sent];
                if (bus.in_ready) sent++;
            end else begin
                bus.in_valid   = 1'b0;
                bus.dense_vals = '0;
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        check_val("bp_sent", 64'(sent), 64'd5);
        check_val("bp_received", 64'(got), 64'd5);
        @(negedge clk);
        check_val("bp_no_dup", 64'(bus.out_valid), 64'd0);
        exp_cnt  = 3;
        exp_cnt2 = 3;
        check_counts("bp");
    endtask

    localparam logic [63:0] BLK_A = {16'h0001, 16'h0005, 16'hFFF9, 16'h0003};

    initial begin
        rst            = 1'b1;
        cnt_clear      = 1'b0;
        bus.in_valid   = 1'b0;
        bus.dense_vals = '0;
        bus.out_ready  = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_val("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check_val("rst_mask", 64'(bus.mask), 64'd0);
        check_val("rst_packed", 64'(bus.packed_vals), 64'd0);
        check_val("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check_counts("rst");

        run_block("basic",   pack4(16'd3, 16'hFFF9, 16'd5, 16'd1),       4'b0110, 32'hFFF9_0005, 1'b1, 1'b0);
        run_block("ties",    pack4(16'd4, 16'hFFFC, 16'd4, 16'd4),       4'b0011, 32'h0004_FFFC, 1'b1, 1'b0);
        run_block("zero",    '0,                                         4'b0011, 32'h0000_0000, 1'b0, 1'b0);
        run_block("extreme", pack4(16'h8000, 16'd0, 16'd0, 16'h7FFF),    4'b1001, 32'h8000_7FFF, 1'b0, 1'b0);
        run_block("single",  pack4(16'd0, 16'd0, 16'd9, 16'd0),         4'b0101, 32'h0000_0009, 1'b0, 1'b0);
        run_block("three",   pack4(16'hFFFF, 16'd2, 16'hFFFD, 16'd0),    4'b0110, 32'h0002_FFFD, 1'b1, 1'b0);
        run_block("tie_hi",  pack4(16'd0, 16'hFFF8, 16'd0, 16'd8),       4'b1010, 32'hFFF8_0008, 1'b0, 1'b0);
        run_block("sat4",    BLK_A, 4'b0110, 32'hFFF9_0005, 1'b1, 1'b0);
        run_block("sat5",    BLK_A, 4'b0110, 32'hFFF9_0005, 1'b1, 1'b0);
        run_block("clr_xfer", BLK_A, 4'b0110, 32'hFFF9_0005, 1'b1, 1'b1);
        run_block("after_clr", BLK_A, 4'b0110, 32'hFFF9_0005, 1'b1, 1'b0);

        @(negedge clk);
        cnt_clear = 1'b1;
        @(negedge clk);
        cnt_clear = 1'b0;
        exp_cnt   = 0;
        exp_cnt2  = 0;
        check_counts("idle_clr");

        run_stream();

        // Two lossy blocks in flight with the consumer stalled, then reset.
        @(negedge clk);
        bus.out_ready  = 1'b0;
        bus.in_valid   = 1'b1;
        bus.dense_vals = BLK_A;
        @(posedge clk);
        #1 bus.dense_vals = pack4(16'd4, 16'hFFFC, 16'd4, 16'd4);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(negedge clk);
        check_val("inflight_valid", 64'(bus.out_valid), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        exp_cnt  = 0;
        exp_cnt2 = 0;
        check_val("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
        check_val("mid_rst_mask", 64'(bus.mask), 64'd0);
        check_counts("mid_rst");
        run_block("post_rst", pack4(16'h8000, 16'd0, 16'd0, 16'h7FFF), 4'b1001, 32'h8000_7FFF, 1'b0, 1'b0);
        run_block("post_rst2", BLK_A, 4'b0110, 32'hFFF9_0005, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
